branch_predictor: RTL and testbench

- Dynamic branch predictor and misprediction controller for the pipelined core.
- Predicts conditional-branch direction and target at fetch from a direct-mapped table of 2-bit saturating counters with tag and target.
- Trains that table from the execute-stage branch resolution result (taken flag plus computed target).
- Raises the flush/redirect request when a prediction was wrong.

---
 rtl/branch_predictor_pkg.sv | 20 ++
 rtl/branch_predictor_if.sv | 45 ++++
 rtl/sat_counter2.sv | 35 +++
 rtl/branch_predictor.sv | 181 ++++++++++++++++++
 tb/tb_branch_predictor.sv | 320 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/branch_predictor_pkg.sv
// ----------------------------------------------------------------------------
// branch_predictor_pkg
// Shared constants and types for the bimodal / gshare branch predictor.
//   - 2-bit saturating counter encodings (strongly/weakly not-taken/taken)
//   - default table depth and instruction size
// Optional build macro used by the predictor: DIAGV2_GSHARE_EN
// ----------------------------------------------------------------------------
package branch_predictor_pkg;

    typedef logic [1:0] ctr_t;

    localparam ctr_t CtrSNT = 2'b00;
    localparam ctr_t CtrWNT = 2'b01;
    localparam ctr_t CtrWT  = 2'b10;
    localparam ctr_t CtrST  = 2'b11;

    localparam int BpEntries  = 64;
    localparam int InstrBytes = 4;

endpackage : branch_predictor_pkg

// File: rtl/branch_predictor_if.sv
// ----------------------------------------------------------------------------
// branch_predictor_if
// Bundles the fetch lookup, execute-stage resolution and flush/redirect
// signals of the branch predictor.
//   master : core pipeline side (drives fetch_pc and res_*, receives
//            predictions and the mispredict/redirect request)
//   slave  : predictor side
// ----------------------------------------------------------------------------
interface branch_predictor_if #(
    parameter int XLEN = 64
);
    // Fetch-side lookup
    logic [XLEN-1:0] fetch_pc;
    logic            pred_taken;
    logic [XLEN-1:0] pred_target;

    // Execute-side resolution
    logic            res_valid;
    logic            res_stall;
    logic [XLEN-1:0] res_pc;
    logic            res_taken;
    logic [XLEN-1:0] res_target;
    logic            res_pred_taken;
    logic [XLEN-1:0] res_pred_target;

    // Flush / redirect request
    logic            mispredict;
    logic [XLEN-1:0] redirect_pc;

    modport master (
        output fetch_pc,
        output res_valid, res_stall, res_pc, res_taken, res_target,
        output res_pred_taken, res_pred_target,
        input  pred_taken, pred_target,
        input  mispredict, redirect_pc
    );

    modport slave (
        input  fetch_pc,
        input  res_valid, res_stall, res_pc, res_taken, res_target,
        input  res_pred_taken, res_pred_target,
        output pred_taken, pred_target,
        output mispredict, redirect_pc
    );
endinterface : branch_predictor_if

// File: rtl/sat_counter2.sv
// ----------------------------------------------------------------------------
// sat_counter2
// Combinational next-state function of a 2-bit saturating counter.
//   ctr      in  current counter value
//   taken    in  resolved branch outcome
//   ctr_next out counter moved one step toward the outcome, clamped at
//                strongly-taken / strongly-not-taken
// ----------------------------------------------------------------------------
module sat_counter2
    import branch_predictor_pkg::*;
(
    input  ctr_t ctr,
    input  logic taken,
    output ctr_t ctr_next
);

    // Saturating step toward the resolved outcome
    always_comb begin
        ctr_next = ctr;
        if (taken) begin
            if (ctr != CtrST) begin
                ctr_next = ctr + 2'd1;
            end else begin
                ctr_next = CtrST;
            end
        end else begin
            if (ctr != CtrSNT) begin
                ctr_next = ctr - 2'd1;
            end else begin
                ctr_next = CtrSNT;
            end
        end
    end

endmodule : sat_counter2

// File: rtl/branch_predictor.sv
// ----------------------------------------------------------------------------
// branch_predictor
// Direct-mapped dynamic branch predictor with misprediction detection.
//   clk, rst_n      core clock, asynchronous active-low reset
//   bp (slave)      fetch_pc -> pred_taken/pred_target (zero latency lookup)
//                   res_* resolution -> table training, mispredict/redirect_pc
// Each entry holds valid, tag, word-aligned target and a 2-bit counter.
// Lookup and training in the same cycle see the pre-update entry.
// Optional feature macro: DIAGV2_GSHARE_EN
//   defined   : GHR_BITS global history XORed into the table index
//   undefined : pure bimodal indexing
// ----------------------------------------------------------------------------
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int XLEN     = 64,
    parameter int ENTRIES  = BpEntries,
    parameter int GHR_BITS = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    branch_predictor_if.slave bp
);

    localparam int IDX_BITS = $clog2(ENTRIES);
    localparam int TAG_W    = XLEN - IDX_BITS - 2;
    localparam int TGT_W    = XLEN - 2;

    if (ENTRIES < 4 || (1 << IDX_BITS) != ENTRIES || GHR_BITS > IDX_BITS
        || GHR_BITS < 2) begin : g_bad_cfg
        $error("branch_predictor: illegal ENTRIES/GHR_BITS configuration");
    end

    // Table storage; valid and ctr carry the async clear, tag/target do not
    logic [ENTRIES-1:0] valid_r;
    ctr_t               ctr_r [ENTRIES];
    logic [TAG_W-1:0]   tag_r [ENTRIES];
    logic [TGT_W-1:0]   tgt_r [ENTRIES];

    logic [IDX_BITS-1:0] f_idx_s;
    logic [IDX_BITS-1:0] r_idx_s;
    logic [TAG_W-1:0]    f_tag_s;
    logic [TAG_W-1:0]    r_tag_s;
    logic                f_hit_s;
    logic                r_hit_s;
    logic                pred_taken_s;
    logic [XLEN-1:0]     pred_target_s;
    logic                act_s;
    logic                mispredict_s;
    logic [XLEN-1:0]     redirect_pc_s;
    ctr_t                ctr_cur_s;
    ctr_t                ctr_sat_s;
    ctr_t                ctr_wdata_s;
    logic                ctr_we_s;
    logic                tgt_we_s;
    logic                alloc_s;

`ifdef DIAGV2_GSHARE_EN
    logic [GHR_BITS-1:0] ghr_r;

    // Global history, shifted on every active resolution
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ghr_r <= '0;
        end else if (act_s) begin
            ghr_r <= {ghr_r[GHR_BITS-2:0], bp.res_taken};
        end
    end

    // Index/tag extraction; training hashes with the pre-shift history
    always_comb begin
        f_idx_s = bp.fetch_pc[IDX_BITS+1:2] ^ IDX_BITS'(ghr_r);
        r_idx_s = bp.res_pc[IDX_BITS+1:2]   ^ IDX_BITS'(ghr_r);
        f_tag_s = bp.fetch_pc[XLEN-1:IDX_BITS+2];
        r_tag_s = bp.res_pc[XLEN-1:IDX_BITS+2];
    end
`else
    // Index/tag extraction, bimodal
    always_comb begin
        f_idx_s = bp.fetch_pc[IDX_BITS+1:2];
        r_idx_s = bp.res_pc[IDX_BITS+1:2];
        f_tag_s = bp.fetch_pc[XLEN-1:IDX_BITS+2];
        r_tag_s = bp.res_pc[XLEN-1:IDX_BITS+2];
    end
`endif

    // Table reads for both the fetch lookup and the resolving branch
    always_comb begin
        f_hit_s   = valid_r[f_idx_s] && (tag_r[f_idx_s] == f_tag_s);
        r_hit_s   = valid_r[r_idx_s] && (tag_r[r_idx_s] == r_tag_s);
        ctr_cur_s = ctr_r[r_idx_s];
    end

    // Fetch prediction; fall-through target wraps modulo 2^XLEN
    always_comb begin
        pred_taken_s = f_hit_s && ctr_r[f_idx_s][1];
        if (pred_taken_s) begin
            pred_target_s = {tgt_r[f_idx_s], 2'b00};
        end else begin
            pred_target_s = bp.fetch_pc + XLEN'(InstrBytes);
        end
    end

    // Misprediction check: direction, or target when actually taken.
    // rst_n gating keeps the flush request quiet while reset is held.
    always_comb begin
        act_s        = bp.res_valid && !bp.res_stall;
        mispredict_s = act_s && rst_n &&
                       ((bp.res_taken != bp.res_pred_taken) ||
                        (bp.res_taken && (bp.res_target != bp.res_pred_target)));
        if (!mispredict_s) begin
            redirect_pc_s = '0;
        end else if (bp.res_taken) begin
            redirect_pc_s = bp.res_target;
        end else begin
            redirect_pc_s = bp.res_pc + XLEN'(InstrBytes);
        end
    end

    sat_counter2 u_sat_counter2 (
        .ctr      (ctr_cur_s),
        .taken    (bp.res_taken),
        .ctr_next (ctr_sat_s)
    );

    // Training decision: update on hit, allocate only taken misses
    always_comb begin
        ctr_we_s    = 1'b0;
        tgt_we_s    = 1'b0;
        alloc_s     = 1'b0;
        ctr_wdata_s = ctr_sat_s;
        if (act_s && r_hit_s) begin
            ctr_we_s    = 1'b1;
            tgt_we_s    = bp.res_taken;
            ctr_wdata_s = ctr_sat_s;
        end else if (act_s && bp.res_taken) begin
            ctr_we_s    = 1'b1;
            tgt_we_s    = 1'b1;
            alloc_s     = 1'b1;
            ctr_wdata_s = CtrWT;
        end else begin
            ctr_we_s    = 1'b0;
            tgt_we_s    = 1'b0;
            alloc_s     = 1'b0;
            ctr_wdata_s = ctr_sat_s;
        end
    end

    // Valid bits and counters, cleared asynchronously by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                ctr_r[i] <= CtrWNT;
            end
        end else begin
            if (alloc_s) begin
                valid_r[r_idx_s] <= 1'b1;
            end
            if (ctr_we_s) begin
                ctr_r[r_idx_s] <= ctr_wdata_s;
            end
        end
    end

    // Tag and target payload; contents only matter behind a valid bit
    always_ff @(posedge clk) begin
        if (alloc_s) begin
            tag_r[r_idx_s] <= r_tag_s;
        end
        if (tgt_we_s) begin
            tgt_r[r_idx_s] <= bp.res_target[XLEN-1:2];
        end
    end

    assign bp.pred_taken  = pred_taken_s;
    assign bp.pred_target = pred_target_s;
    assign bp.mispredict  = mispredict_s;
    assign bp.redirect_pc = redirect_pc_s;

endmodule : branch_predictor

// File: tb/tb_branch_predictor.sv
// ----------------------------------------------------------------------------
// tb_branch_predictor
// Self-checking bench for branch_predictor (default bimodal build,
// XLEN=64, ENTRIES=64). A table model indexed by (pc/4) mod 64 with tag
// pc/256 predicts every output; directed scenarios plus random traffic.
// ----------------------------------------------------------------------------
module tb_branch_predictor;

    localparam int XLEN = 64;
    localparam int NENT = 64;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    branch_predictor_if #(.XLEN(XLEN)) bif ();

    branch_predictor #(.XLEN(XLEN), .ENTRIES(NENT), .GHR_BITS(6)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bp    (bif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    bit          m_valid [NENT];
    logic [63:0] m_tag   [NENT];
    logic [63:0] m_tgt   [NENT];
    int          m_ctr   [NENT];

    function automatic int midx(input logic [63:0] pc);
        return int'((pc / 64'd4) % 64'(NENT));
    endfunction

    function automatic logic [63:0] mtag(input logic [63:0] pc);
        return pc / 64'(4 * NENT);
    endfunction

    function automatic bit m_hit(input logic [63:0] pc);
        return m_valid[midx(pc)] && (m_tag[midx(pc)] == mtag(pc));
    endfunction

    function automatic bit m_ptaken(input logic [63:0] pc);
        return m_hit(pc) && (m_ctr[midx(pc)] >= 2);
    endfunction

    function automatic logic [63:0] m_ptgt(input logic [63:0] pc);
        logic [63:0] fall;
        fall = pc + 64'd4;
        return m_ptaken(pc) ? m_tgt[midx(pc)] : fall;
    endfunction

    function automatic bit m_mis(input bit rv, input bit rs, input bit rt,
                                 input logic [63:0] rtgt, input bit rpt,
                                 input logic [63:0] rptgt);
        return rv && !rs && ((rt != rpt) || (rt && (rtgt != rptgt)));
    endfunction

    function automatic logic [63:0] m_redir(input bit mis, input logic [63:0] rpc,
                                            input bit rt, input logic [63:0] rtgt);
        logic [63:0] fall;
        fall = rpc + 64'd4;
        if (!mis) return 64'd0;
        return rt ? rtgt : fall;
    endfunction

    function automatic void m_reset();
        for (int i = 0; i < NENT; i++) begin
            m_valid[i] = 1'b0;
            m_ctr[i]   = 1;
        end
    endfunction

    function automatic void m_train(input logic [63:0] pc, input bit t,
                                    input logic [63:0] tgt);
        int i;
        i = midx(pc);
        if (m_hit(pc)) begin
            if (t) begin
                m_ctr[i] = (m_ctr[i] == 3) ? 3 : m_ctr[i] + 1;
                m_tgt[i] = tgt & ~64'd3;
            end else begin
                m_ctr[i] = (m_ctr[i] == 0) ? 0 : m_ctr[i] - 1;
            end
        end else if (t) begin
            m_valid[i] = 1'b1;
            m_tag[i]   = mtag(pc);
            m_tgt[i]   = tgt & ~64'd3;
            m_ctr[i]   = 2;
        end
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic drive(input logic [63:0] fpc, input bit rv, input bit rs,
                         input logic [63:0] rpc, input bit rt, input logic [63:0] rtgt,
                         input bit rpt, input logic [63:0] rptgt);
        bif.fetch_pc        = fpc;
        bif.res_valid       = rv;
        bif.res_stall       = rs;
        bif.res_pc          = rpc;
        bif.res_taken       = rt;
        bif.res_target      = rtgt;
        bif.res_pred_taken  = rpt;
        bif.res_pred_target = rptgt;
    endtask

    // Clock edge, then mirror the training into the model
    task automatic advance();
        @(posedge clk);
        if (rst_n && bif.res_valid && !bif.res_stall)
            m_train(bif.res_pc, bif.res_taken, bif.res_target);
        #1;
    endtask

    // Train a branch taken, presenting the model prediction with it
    task automatic train_taken(input logic [63:0] pc, input logic [63:0] tgt);
        drive(64'd0, 1'b1, 1'b0, pc, 1'b1, tgt, m_ptaken(pc), m_ptgt(pc));
        advance();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        m_reset();
        drive(64'h1000, 1'b1, 1'b0, 64'h40, 1'b1, 64'h80, 1'b0, 64'h0);
        #2;
        checks++; if (bif.pred_taken !== 1'b0) begin errors++; $display("FAIL rst_pred_taken: got %0b want 0", bif.pred_taken); end
        checks++; if (bif.pred_target !== 64'h1004) begin errors++; $display("FAIL rst_pred_target: got %0h want 1004", bif.pred_target); end
        checks++; if (bif.mispredict !== 1'b0) begin errors++; $display("FAIL rst_mispredict: got %0b want 0", bif.mispredict); end
        checks++; if (bif.redirect_pc !== 64'h0) begin errors++; $display("FAIL rst_redirect: got %0h want 0", bif.redirect_pc); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        drive(64'h1000, 1'b0, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0, 64'h0);
        @(negedge clk);
        checks++; if (bif.pred_taken !== 1'b0) begin errors++; $display("FAIL post_rst_pred: got %0b want 0", bif.pred_taken); end
        checks++; if (bif.pred_target !== 64'h1004) begin errors++; $display("FAIL post_rst_target: got %0h want 1004", bif.pred_target); end
        checks++; if (bif.mispredict !== 1'b0) begin errors++; $display("FAIL post_rst_mis: got %0b want 0", bif.mispredict); end
        advance();
    endtask

    task automatic test_first_alloc();
        drive(64'h1000, 1'b1, 1'b0, 64'h1000, 1'b1, 64'h0F00, 1'b0, 64'h1004);
        @(negedge clk);
        checks++; if (bif.mispredict !== 1'b1) begin errors++; $display("FAIL alloc_mis: got %0b want 1", bif.mispredict); end
        checks++; if (bif.redirect_pc !== 64'h0F00) begin errors++; $display("FAIL alloc_redirect: got %0h want f00", bif.redirect_pc); end
        checks++; if (bif.pred_taken !== 1'b0) begin errors++; $display("FAIL alloc_same_cycle_pred: got %0b want 0", bif.pred_taken); end
        advance();
        drive(64'h1000, 1'b0, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0, 64'h0);
        @(negedge clk);
        checks++; if (bif.pred_taken !== 1'b1) begin errors++; $display("FAIL alloc_pred: got %0b want 1", bif.pred_taken); end
        checks++; if (bif.pred_target !== 64'h0F00) begin errors++; $display("FAIL alloc_target: got %0h want f00", bif.pred_target); end
        advance();
    endtask

    // Entry at ctr=10: taken, taken, not-taken, not-taken -> 11,11,10,01
    task automatic test_counter_seq();
        bit          outc [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        bit          want [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        bit          pt;
        logic [63:0] ptg;
        for (int k = 0; k < 4; k++) begin
            pt  = m_ptaken(64'h1000);
            ptg = m_ptgt(64'h1000);
            drive(64'h1000, 1'b1, 1'b0, 64'h1000, outc[k], 64'h0F00, pt, ptg);
            @(negedge clk);
            if (k == 2) begin
                checks++; if (bif.mispredict !== 1'b1) begin errors++; $display("FAIL seq_nt_mis: got %0b want 1", bif.mispredict); end
                checks++; if (bif.redirect_pc !== 64'h1004) begin errors++; $display("FAIL seq_nt_redirect: got %0h want 1004", bif.redirect_pc); end
            end else begin
                checks++; if (bif.mispredict !== m_mis(1'b1, 1'b0, outc[k], 64'h0F00, pt, ptg)) begin errors++; $display("FAIL seq_mis_%0d: got %0b", k, bif.mispredict); end
            end
            advance();
            drive(64'h1000, 1'b0, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0, 64'h0);
            @(negedge clk);
            checks++; if (bif.pred_taken !== want[k]) begin errors++; $display("FAIL seq_pred_%0d: got %0b want %0b", k, bif.pred_taken, want[k]); end
            advance();
        end
    endtask

    // 0x1000 sits at ctr=01 here; a stalled taken branch must train once
    task automatic test_stall();
        for (int k = 0; k < 3; k++) begin
            drive(64'h1000, 1'b1, 1'b1, 64'h1000, 1'b1, 64'h0F00, 1'b0, 64'h1004);
            @(negedge clk);
            checks++; if (bif.mispredict !== 1'b0) begin errors++; $display("FAIL stall_mis_%0d: got %0b want 0", k, bif.mispredict); end
            checks++; if (bif.pred_taken !== 1'b0) begin errors++; $display("FAIL stall_pred_%0d: got %0b want 0", k, bif.pred_taken); end
            advance();
        end
        drive(64'h1000, 1'b1, 1'b0, 64'h1000, 1'b1, 64'h0F00, 1'b0, 64'h1004);
        @(negedge clk);
        checks++; if (bif.mispredict !== 1'b1) begin errors++; $display("FAIL stall_release_mis: got %0b want 1", bif.mispredict); end
        checks++; if (bif.redirect_pc !== 64'h0F00) begin errors++; $display("FAIL stall_release_redirect: got %0h want f00", bif.redirect_pc); end
        advance();
        drive(64'h1000, 1'b1, 1'b0, 64'h1000, 1'b0, 64'h0, 1'b1, 64'h0F00);
        @(negedge clk);
        checks++; if (bif.pred_taken !== 1'b1) begin errors++; $display("FAIL stall_once_pred: got %0b want 1", bif.pred_taken); end
        advance();
        drive(64'h1000, 1'b0, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0, 64'h0);
        @(negedge clk);
        checks++; if (bif.pred_taken !== 1'b0) begin errors++; $display("FAIL stall_once_after_nt: got %0b want 0", bif.pred_taken); end
        advance();
    endtask

    task automatic test_alias();
        train_taken(64'h1000, 64'h0F00);
        drive(64'h1100, 1'b1, 1'b0, 64'h1100, 1'b1, 64'h5000, 1'b0, 64'h1104);
        @(negedge clk);
        checks++; if (bif.pred_taken !== 1'b0) begin errors++; $display("FAIL alias_miss_pred: got %0b want 0", bif.pred_taken); end
        checks++; if (bif.pred_target !== 64'h1104) begin errors++; $display("FAIL alias_miss_target: got %0h want 1104", bif.pred_target); end
        advance();
        drive(64'h1000, 1'b0, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0, 64'h0);
        @(negedge clk);
        checks++; if (bif.pred_taken !== 1'b0) begin errors++; $display("FAIL alias_old_pred: got %0b want 0", bif.pred_taken); end
        advance();
        drive(64'h1100, 1'b0, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0, 64'h0);
        @(negedge clk);
        checks++; if (bif.pred_target !== 64'h5000) begin errors++; $display("FAIL alias_new_target: got %0h want 5000", bif.pred_target); end
        advance();
    endtask

    task automatic test_wrong_target();
        train_taken(64'h3000, 64'h2000);
        drive(64'h3000, 1'b1, 1'b0, 64'h3000, 1'b1, 64'h2040, 1'b1, 64'h2000);
        @(negedge clk);
        checks++; if (bif.mispredict !== 1'b1) begin errors++; $display("FAIL wt_mis: got %0b want 1", bif.mispredict); end
        checks++; if (bif.redirect_pc !== 64'h2040) begin errors++; $display("FAIL wt_redirect: got %0h want 2040", bif.redirect_pc); end
        checks++; if (bif.pred_target !== 64'h2000) begin errors++; $display("FAIL wt_same_cycle_old: got %0h want 2000", bif.pred_target); end
        advance();
        // Misaligned target: full compare, stored without the low bits
        drive(64'h3000, 1'b1, 1'b0, 64'h3000, 1'b1, 64'h2046, 1'b1, 64'h2044);
        @(negedge clk);
        checks++; if (bif.pred_target !== 64'h2040) begin errors++; $display("FAIL wt_updated_target: got %0h want 2040", bif.pred_target); end
        checks++; if (bif.mispredict !== 1'b1) begin errors++; $display("FAIL misalign_mis: got %0b want 1", bif.mispredict); end
        checks++; if (bif.redirect_pc !== 64'h2046) begin errors++; $display("FAIL misalign_redirect: got %0h want 2046", bif.redirect_pc); end
        advance();
        drive(64'h3000, 1'b0, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0, 64'h0);
        @(negedge clk);
        checks++; if (bif.pred_target !== 64'h2044) begin errors++; $display("FAIL misalign_stored: got %0h want 2044", bif.pred_target); end
        advance();
    endtask

    task automatic test_wrap();
        drive(64'hFFFF_FFFF_FFFF_FFFC, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 64'h0, 1'b1, 64'h40);
        @(negedge clk);
        checks++; if (bif.pred_target !== 64'h0) begin errors++; $display("FAIL wrap_pred_target: got %0h want 0", bif.pred_target); end
        checks++; if (bif.mispredict !== 1'b1) begin errors++; $display("FAIL wrap_mis: got %0b want 1", bif.mispredict); end
        checks++; if (bif.redirect_pc !== 64'h0) begin errors++; $display("FAIL wrap_redirect: got %0h want 0", bif.redirect_pc); end
        advance();
    endtask

    task automatic test_reset_mid();
        drive(64'h3000, 1'b1, 1'b0, 64'h3000, 1'b1, 64'h7000, 1'b0, 64'h3004);
        #3;
        rst_n = 1'b0;
        m_reset();
        #1;
        checks++; if (bif.pred_taken !== 1'b0) begin errors++; $display("FAIL midrst_pred: got %0b want 0", bif.pred_taken); end
        checks++; if (bif.pred_target !== 64'h3004) begin errors++; $display("FAIL midrst_target: got %0h want 3004", bif.pred_target); end
        checks++; if (bif.mispredict !== 1'b0) begin errors++; $display("FAIL midrst_mis: got %0b want 0", bif.mispredict); end
        checks++; if (bif.redirect_pc !== 64'h0) begin errors++; $display("FAIL midrst_redirect: got %0h want 0", bif.redirect_pc); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        drive(64'h3000, 1'b0, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0, 64'h0);
        @(negedge clk);
        checks++; if (bif.pred_taken !== 1'b0) begin errors++; $display("FAIL midrst_cleared: got %0b want 0", bif.pred_taken); end
        advance();
    endtask

    task automatic test_random();
        logic [63:0] fpc, rpc, rtgt, rptgt, e_tg, e_red;
        bit          rv, rs, rt, rpt, e_pt, e_mis;
        for (int n = 0; n < 500; n++) begin
            fpc  = 64'h10000 | (64'($urandom_range(0, 3)) << 8) | (64'($urandom_range(0, 7)) << 2);
            rpc  = 64'h10000 | (64'($urandom_range(0, 3)) << 8) | (64'($urandom_range(0, 7)) << 2);
            rv   = ($urandom_range(0, 3) != 0);
            rs   = ($urandom_range(0, 4) == 0);
            rt   = $urandom_range(0, 1);
            if ($urandom_range(0, 5) == 0) rtgt = {$urandom, $urandom};
            else rtgt = 64'h8000 + 64'($urandom_range(0, 15)) * 64'd4 + (($urandom_range(0, 7) == 0) ? 64'd2 : 64'd0);
            if ($urandom_range(0, 3) != 0) begin
                rpt   = m_ptaken(rpc);
                rptgt = m_ptgt(rpc);
            end else begin
                rpt   = $urandom_range(0, 1);
                rptgt = ($urandom_range(0, 1) == 1) ? rtgt : {$urandom, $urandom};
            end
            drive(fpc, rv, rs, rpc, rt, rtgt, rpt, rptgt);
            e_pt  = m_ptaken(fpc);
            e_tg  = m_ptgt(fpc);
            e_mis = m_mis(rv, rs, rt, rtgt, rpt, rptgt);
            e_red = m_redir(e_mis, rpc, rt, rtgt);
            @(negedge clk);
            checks++; if (bif.pred_taken !== e_pt) begin errors++; $display("FAIL rand_pred_taken[%0d]: got %0b want %0b", n, bif.pred_taken, e_pt); end
            checks++; if (bif.pred_target !== e_tg) begin errors++; $display("FAIL rand_pred_target[%0d]: got %0h want %0h", n, bif.pred_target, e_tg); end
            checks++; if (bif.mispredict !== e_mis) begin errors++; $display("FAIL rand_mispredict[%0d]: got %0b want %0b", n, bif.mispredict, e_mis); end
            checks++; if (bif.redirect_pc !== e_red) begin errors++; $display("FAIL rand_redirect[%0d]: got %0h want %0h", n, bif.redirect_pc, e_red); end
            advance();
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_first_alloc();
        test_counter_seq();
        test_stall();
        test_alias();
        test_wrong_target();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_branch_predictor
